// File: rtl/width_conv_pkg.sv
// Shared helpers for the width converters: parameter check macro, clog2
// and lane placement of the n-th beat within a word.
`ifndef WIDTH_CONV_PKG_SV
`define WIDTH_CONV_PKG_SV

`define WIDTH_CONV_PARAM_CHECK(cond, msg) \
  if (!(cond)) begin : g_param_check \
    $error(msg); \
  end

package width_conv_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // MSB-first places beat 0 in the top lane so the word reads {first, second, ...}
  function automatic int lane_of(input int n, input int ratio, input bit msb_first);
    return msb_first ? (ratio - 1 - n) : n;
  endfunction

endpackage

`endif

// File: rtl/width_conv_out_slot.sv
// One-entry output register with valid/ready handshake: load, hold or pop.
// free_o says a load this cycle will not overwrite an undelivered entry.
module width_conv_out_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         free_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/width_upsize_packer.sv
// Packs RATIO narrow beats into one wide word with keep bits and early flush
// on in_last; the finished word is handed to a one-entry output slot.
module width_upsize_packer
  import width_conv_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int RATIO     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IN_W*RATIO-1:0] out_data,
  output logic [RATIO-1:0]      out_keep,
  output logic                  out_last,
  output logic                  partial
);

  localparam int OUT_W  = IN_W * RATIO;
  localparam int CW     = (clog2(RATIO) < 1) ? 1 : clog2(RATIO);
  localparam int SLOT_W = OUT_W + RATIO + 1;

  `WIDTH_CONV_PARAM_CHECK(IN_W >= 1 && RATIO >= 1, "width_upsize_packer: IN_W and RATIO must be >= 1")

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic [RATIO-1:0]  keep_q, keep_d;

  logic              accept;
  logic              completing;
  int                lane;
  logic [OUT_W-1:0]  merged_data;
  logic [RATIO-1:0]  merged_keep;
  logic [SLOT_W-1:0] slot_in, slot_out;
  logic              slot_free;

  assign accept     = in_valid && in_ready;
  assign completing = accept && ((cnt_q == CW'(RATIO - 1)) || in_last);

  // Accumulator contents with the current beat dropped into its lane
  always_comb begin
    lane        = lane_of(int'(cnt_q), RATIO, MSB_FIRST != 0);
    merged_data = acc_q;
    merged_keep = keep_q;
    for (int k = 0; k < RATIO; k++) begin
      if (k == lane) begin
        merged_data[k*IN_W +: IN_W] = in_data;
        merged_keep[k]              = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    keep_d = keep_q;
    if (completing) begin
      cnt_d  = '0;
      acc_d  = '0;
      keep_d = '0;
    end else if (accept) begin
      cnt_d  = cnt_q + CW'(1);
      acc_d  = merged_data;
      keep_d = merged_keep;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      keep_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      keep_q <= keep_d;
    end
  end

  assign slot_in = {in_last, merged_keep, merged_data};

  width_conv_out_slot #(
    .W(SLOT_W)
  ) u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (completing),
    .data_i  (slot_in),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (slot_out),
    .free_o  (slot_free)
  );

  assign in_ready = slot_free;
  assign out_data = slot_out[OUT_W-1:0];
  assign out_keep = slot_out[OUT_W +: RATIO];
  assign out_last = slot_out[SLOT_W-1];
  assign partial  = (cnt_q != '0);

endmodule

// File: tb/tb_width_upsize_packer.sv
// Directed bench for width_upsize_packer: four parameterisations share clock,
// reset, in_data and in_last; each has its own in_valid/out_ready.
module tb_width_upsize_packer;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] in_data;
  logic       in_last;

  // a: RATIO=2 MSB-first, b: RATIO=4 LSB-first, c: RATIO=4 MSB-first, d: RATIO=1
  logic        a_v, a_rdy, a_or, a_ov, a_last, a_part;
  logic [15:0] a_data;
  logic [1:0]  a_keep;
  logic        b_v, b_rdy, b_or, b_ov, b_last, b_part;
  logic [31:0] b_data;
  logic [3:0]  b_keep;
  logic        c_v, c_rdy, c_or, c_ov, c_last, c_part;
  logic [31:0] c_data;
  logic [3:0]  c_keep;
  logic        d_v, d_rdy, d_or, d_ov, d_last, d_part;
  logic [7:0]  d_data;
  logic [0:0]  d_keep;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  width_upsize_packer #(.IN_W(8), .RATIO(2), .MSB_FIRST(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_v), .in_ready(a_rdy), .in_data(in_data),
    .in_last(in_last), .out_valid(a_ov), .out_ready(a_or), .out_data(a_data),
    .out_keep(a_keep), .out_last(a_last), .partial(a_part));

  width_upsize_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_v), .in_ready(b_rdy), .in_data(in_data),
    .in_last(in_last), .out_valid(b_ov), .out_ready(b_or), .out_data(b_data),
    .out_keep(b_keep), .out_last(b_last), .partial(b_part));

  width_upsize_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_v), .in_ready(c_rdy), .in_data(in_data),
    .in_last(in_last), .out_valid(c_ov), .out_ready(c_or), .out_data(c_data),
    .out_keep(c_keep), .out_last(c_last), .partial(c_part));

  width_upsize_packer #(.IN_W(8), .RATIO(1), .MSB_FIRST(1)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(d_v), .in_ready(d_rdy), .in_data(in_data),
    .in_last(in_last), .out_valid(d_ov), .out_ready(d_or), .out_data(d_data),
    .out_keep(d_keep), .out_last(d_last), .partial(d_part));

  typedef struct {
    logic        v;
    logic [7:0]  data;
    logic        last;
    logic        ordy;
    logic        exp_rdy;
    logic        exp_ov;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
    logic        exp_last;
    logic        exp_part;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0,    1'b0, 1'b1};
    tbl[1] = '{1'b1, 8'h6B, 1'b1, 1'b1, 1'b1, 1'b1, 32'h5A6B0000, 4'b1100, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 8'h7C, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0,    1'b0, 1'b1};
    tbl[3] = '{1'b1, 8'h8D, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0,    1'b0, 1'b1};
    tbl[4] = '{1'b1, 8'h9E, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0,    1'b0, 1'b1};
    tbl[5] = '{1'b1, 8'hAF, 1'b0, 1'b1, 1'b1, 1'b1, 32'h7C8D9EAF, 4'hF,    1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7C8D9EAF, 4'hF,    1'b0, 1'b0};
    tbl[7] = '{1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1'b1, 32'h7C8D9EAF, 4'hF,    1'b0, 1'b0};
    tbl[8] = '{1'b1, 8'h12, 1'b1, 1'b1, 1'b1, 1'b1, 32'h12000000, 4'b1000, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0,    1'b0, 1'b0};

    rst_n = 1'b0; in_data = 8'h00; in_last = 1'b0;
    a_v = 0; b_v = 0; c_v = 0; d_v = 0;
    a_or = 1; b_or = 1; c_or = 1; d_or = 1;
    #2;
    chk("reset_c_ov",   c_ov,   0);
    chk("reset_c_data", c_data, 0);
    chk("reset_c_keep", c_keep, 0);
    chk("reset_c_last", c_last, 0);
    chk("reset_c_part", c_part, 0);
    chk("reset_a_ov",   a_ov,   0);
    chk("reset_d_data", d_data, 0);
    #20 rst_n = 1'b1;
    cyc();

    // 1: RATIO=2 MSB-first
    a_v = 1; in_data = 8'hA1; in_last = 0;
    #1 chk("t1_in_ready", a_rdy, 1);
    cyc();
    chk("t1_ov_after_first", a_ov, 0);
    chk("t1_partial", a_part, 1);
    in_data = 8'hB2;
    cyc();
    a_v = 0;
    chk("t1_ov", a_ov, 1);
    chk("t1_data", a_data, 16'hA1B2);
    chk("t1_keep", a_keep, 2'b11);
    chk("t1_last", a_last, 0);
    chk("t1_part_clear", a_part, 0);
    cyc();
    chk("t1_ov_popped", a_ov, 0);

    // 2: RATIO=4 LSB-first, eight beats back to back
    for (int i = 0; i < 8; i++) begin
      b_v = 1; in_data = 8'((i + 1) * 8'h11); in_last = 0;
      #1 chk("t2_in_ready", b_rdy, 1);
      cyc();
      if (i == 3) begin
        chk("t2_w0_ov", b_ov, 1);
        chk("t2_w0_data", b_data, 32'h44332211);
        chk("t2_w0_keep", b_keep, 4'hF);
        chk("t2_w0_last", b_last, 0);
      end
      if (i == 7) begin
        chk("t2_w1_ov", b_ov, 1);
        chk("t2_w1_data", b_data, 32'h88776655);
      end
    end
    b_v = 0;
    cyc();
    chk("t2_ov_end", b_ov, 0);

    // 3: table on RATIO=4 MSB-first: flush, fresh word, hold, pop+load
    for (int r = 0; r < 10; r++) begin
      c_v = tbl[r].v; in_data = tbl[r].data; in_last = tbl[r].last; c_or = tbl[r].ordy;
      #1 chk($sformatf("tbl%0d_in_ready", r), c_rdy, tbl[r].exp_rdy);
      cyc();
      chk($sformatf("tbl%0d_ov", r), c_ov, tbl[r].exp_ov);
      chk($sformatf("tbl%0d_partial", r), c_part, tbl[r].exp_part);
      if (tbl[r].exp_ov) begin
        chk($sformatf("tbl%0d_data", r), c_data, tbl[r].exp_data);
        chk($sformatf("tbl%0d_keep", r), c_keep, tbl[r].exp_keep);
        chk($sformatf("tbl%0d_last", r), c_last, tbl[r].exp_last);
      end
    end
    c_v = 0; in_last = 0;

    // 4: backpressure on RATIO=2
    a_or = 0; a_v = 1; in_data = 8'hC3;
    cyc();
    in_data = 8'hD4;
    cyc();
    chk("t4_ov", a_ov, 1);
    chk("t4_data", a_data, 16'hC3D4);
    for (int i = 0; i < 5; i++) begin
      in_data = 8'hE5; in_last = 0;
      #1 chk("t4_hold_in_ready", a_rdy, 0);
      cyc();
      chk("t4_hold_ov", a_ov, 1);
      chk("t4_hold_data", a_data, 16'hC3D4);
      chk("t4_hold_keep", a_keep, 2'b11);
    end
    chk("t4_hold_partial", a_part, 0);
    a_or = 1; in_data = 8'hE5; in_last = 1;
    #1 chk("t4_release_in_ready", a_rdy, 1);
    cyc();
    a_v = 0; in_last = 0;
    chk("t4_nobubble_ov", a_ov, 1);
    chk("t4_next_data", a_data, 16'hE500);
    chk("t4_next_keep", a_keep, 2'b10);
    chk("t4_next_last", a_last, 1);
    cyc();
    chk("t4_ov_end", a_ov, 0);

    // 5: reset mid-word on RATIO=4 MSB-first
    c_or = 1;
    for (int i = 0; i < 3; i++) begin
      c_v = 1; in_data = 8'(i + 1);
      cyc();
    end
    c_v = 0;
    chk("t5_partial_before", c_part, 1);
    rst_n = 1'b0;
    #2;
    chk("t5_rst_ov", c_ov, 0);
    chk("t5_rst_data", c_data, 0);
    chk("t5_rst_keep", c_keep, 0);
    chk("t5_rst_last", c_last, 0);
    chk("t5_rst_part", c_part, 0);
    #2 rst_n = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      c_v = 1; in_data = 8'(8'h0A + i); in_last = 0;
      cyc();
      chk("t5_word_ov", c_ov, (i == 3) ? 1'b1 : 1'b0);
    end
    c_v = 0;
    chk("t5_data", c_data, 32'h0A0B0C0D);
    chk("t5_keep", c_keep, 4'hF);
    cyc();
    chk("t5_single_word", c_ov, 0);

    // 6: RATIO=1 registered pass-through
    d_v = 1; in_data = 8'h3C; in_last = 1;
    #1 chk("t6_in_ready", d_rdy, 1);
    cyc();
    chk("t6_ov", d_ov, 1);
    chk("t6_data", d_data, 8'h3C);
    chk("t6_keep", d_keep, 1'b1);
    chk("t6_last", d_last, 1);
    in_data = 8'h5D; in_last = 0;
    cyc();
    d_v = 0;
    chk("t6b_ov", d_ov, 1);
    chk("t6b_data", d_data, 8'h5D);
    chk("t6b_last", d_last, 0);
    chk("t6b_partial", d_part, 0);
    cyc();
    chk("t6_ov_end", d_ov, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
